mem_arbiter: RTL

//  Two-requester arbiter/sequencer for the single-port 256x8 program/data memory.

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data sequencer for the single-port program/data memory
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Requester identity: 0 = fetch, 1 = data.
  localparam logic SRC_F = 1'b0;
  localparam logic SRC_D = 1'b1;

  state_t            r_state;
  logic              r_last;
  logic              r_win;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_f_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_f_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_grant_d;
  logic              w_serve;

  // Winner selection: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    w_grant_d = SRC_F;
    if (d_req && !f_req) begin
      w_grant_d = SRC_D;
    end else if (f_req && !d_req) begin
      w_grant_d = SRC_F;
    end else begin
      w_grant_d = (r_last == SRC_F) ? SRC_D : SRC_F;
    end
  end

  // Sequencer: IDLE latches the granted access, SERVE performs it, DONE pulses the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= SRC_D;
      r_win     <= SRC_F;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_f_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_f_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (f_req || d_req) begin
            r_win  <= w_grant_d;
            r_last <= w_grant_d;
            if (w_grant_d == SRC_D) begin
              r_addr  <= d_addr;
              r_we    <= d_we;
              r_wdata <= d_wdata;
            end else begin
              r_addr  <= f_addr;
              r_we    <= 1'b0;
              r_wdata <= '0;
            end
            r_state <= S_SERVE;
          end
        end
        S_SERVE: begin
          // Stores leave the load result untouched; the write itself lands in memory on this edge.
          if (!r_we) begin
            if (r_win == SRC_D) begin
              r_d_rdata <= mem_dout;
            end else begin
              r_f_rdata <= mem_dout;
            end
          end
          if (r_win == SRC_D) begin
            r_d_ack <= 1'b1;
          end else begin
            r_f_ack <= 1'b1;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory port is only driven while an access is in flight; reset blocks the write strobe immediately.
  assign w_serve  = (r_state == S_SERVE);
  assign mem_addr = w_serve ? r_addr : '0;
  assign mem_din  = w_serve ? r_wdata : '0;
  assign mem_we   = w_serve & r_we & ~rst;

  // A reset landing in DONE must not let the pending ack escape.
  assign f_ack   = r_f_ack & ~rst;
  assign d_ack   = r_d_ack & ~rst;
  assign f_rdata = r_f_rdata;
  assign d_rdata = r_d_rdata;
  assign busy    = (r_state != S_IDLE);

endmodule
